hud_overlay: RTL and testbench



---
 rtl/hud_overlay.sv | 174 +++++++++++++++++
 tb/tb_hud_overlay.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hud_overlay.sv
// HUD stage: per-frame latch of blood/score, sequential double-dabble BCD conversion,
// and per-pixel classification into a health bar and a 3-digit score field.
module hud_overlay #(
  parameter int BAR_X         = 8,
  parameter int BAR_Y         = 8,
  parameter int BAR_H         = 6,
  parameter int DIGIT_X       = 280,
  parameter int DIGIT_Y       = 8,
  parameter int FLASH_FRAMES  = 8,
  parameter int LOW_THRESHOLD = 25
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        game_frame_clk_rising_edge,
  input  logic [8:0]  PixelX,
  input  logic [8:0]  PixelY,
  input  logic [9:0]  Player_Blood,
  input  logic [7:0]  Total_Score,
  input  logic        Game_Over_On,
  output logic        is_hud,
  output logic [4:0]  hud_index,
  output logic        is_digit,
  output logic [9:0]  digit_address,
  output logic [11:0] Score_BCD,
  output logic        Conv_Busy,
  output logic        Blood_Low
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} conv_state_t;

  localparam logic [10:0] BX = 11'(BAR_X);
  localparam logic [10:0] BY = 11'(BAR_Y);
  localparam logic [10:0] BH = 11'(BAR_H);
  localparam logic [10:0] DX = 11'(DIGIT_X);
  localparam logic [10:0] DY = 11'(DIGIT_Y);
  localparam logic [7:0]  FLASH_INIT = 8'(FLASH_FRAMES);
  localparam logic [7:0]  LOW_LEVEL  = 8'(LOW_THRESHOLD);

  // One double-dabble iteration: BCD field in [19:8], binary in [7:0].
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3; else a[11:8]  = a[11:8];
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3; else a[15:12] = a[15:12];
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3; else a[19:16] = a[19:16];
    return {a[18:0], 1'b0};
  endfunction

  conv_state_t state_r, state_s;
  logic [19:0] shift_r, shift_s;
  logic [3:0]  bit_cnt_r, bit_cnt_s;
  logic [11:0] score_bcd_r, score_bcd_s;
  logic [6:0]  blood_q_r, blood_d_s, blood_next_s;
  logic [7:0]  flash_cnt_r, flash_d_s;
  logic        is_hud_r, is_digit_r;
  logic [4:0]  hud_index_r, hud_idx_s;
  logic [10:0] px_s, py_s;
  logic [4:0]  dx_s;
  logic [2:0]  dy_s;
  logic [3:0]  digit_s;
  logic        bar_int_s, bar_any_s, fill_s, dig_reg_s, blood_low_s;

  assign blood_next_s = (Player_Blood > 10'd100) ? 7'd100 : Player_Blood[6:0];
  assign blood_low_s  = ({1'b0, blood_q_r} < LOW_LEVEL);

  // Conversion engine next state; a frame edge always restarts from the load.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    score_bcd_s = score_bcd_r;
    if (game_frame_clk_rising_edge) begin
      state_s   = SHIFT;
      shift_s   = {12'd0, Total_Score};
      bit_cnt_s = 4'd0;
    end else begin
      case (state_r)
        IDLE:  state_s = IDLE;
        SHIFT: begin
          shift_s   = dabble_step(shift_r);
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd7) state_s = DONE;
          else                   state_s = SHIFT;
        end
        DONE: begin
          score_bcd_s = shift_r[19:8];
          state_s     = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Frame latch of blood and the damage-flash countdown (counts game frames).
  always_comb begin
    blood_d_s = blood_q_r;
    flash_d_s = flash_cnt_r;
    if (game_frame_clk_rising_edge) blood_d_s = blood_next_s;
    else                            blood_d_s = blood_q_r;
    if (Game_Over_On)                                                   flash_d_s = 8'd0;
    else if (game_frame_clk_rising_edge && (blood_next_s < blood_q_r)) flash_d_s = FLASH_INIT;
    else if (game_frame_clk_rising_edge && (flash_cnt_r != 8'd0))      flash_d_s = flash_cnt_r - 8'd1;
    else                                                                flash_d_s = flash_cnt_r;
  end

  assign px_s      = {2'b00, PixelX};
  assign py_s      = {2'b00, PixelY};
  assign bar_int_s = (px_s >= BX) && (px_s <= BX + 11'd99) && (py_s >= BY) && (py_s <= BY + BH - 11'd1);
  assign bar_any_s = (px_s + 11'd1 >= BX) && (px_s <= BX + 11'd100) &&
                     (py_s + 11'd1 >= BY) && (py_s <= BY + BH);
  assign fill_s    = ((px_s - BX) < {4'b0000, blood_q_r});
  assign dig_reg_s = (px_s >= DX) && (px_s <= DX + 11'd23) && (py_s >= DY) && (py_s <= DY + 11'd7);
  assign dx_s      = 5'(px_s - DX);
  assign dy_s      = 3'(py_s - DY);

  // Bar palette selection; border pixels use index 0.
  always_comb begin
    hud_idx_s = 5'd0;
    if (bar_int_s) begin
      if (!fill_s)                     hud_idx_s = 5'd5;
      else if (flash_cnt_r != 8'd0)    hud_idx_s = 5'd4;
      else if (blood_low_s)            hud_idx_s = 5'd3;
      else                             hud_idx_s = 5'd2;
    end else begin
      hud_idx_s = 5'd0;
    end
  end

  // Digit column picks hundreds, tens or ones.
  always_comb begin
    digit_s = 4'd0;
    case (dx_s[4:3])
      2'd0:    digit_s = score_bcd_r[11:8];
      2'd1:    digit_s = score_bcd_r[7:4];
      2'd2:    digit_s = score_bcd_r[3:0];
      default: digit_s = 4'd0;
    endcase
  end

  assign digit_address = dig_reg_s ? {digit_s, dy_s, dx_s[2:0]} : 10'd0;

  // State registers; pixel flags registered to line up with the ROM read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      shift_r     <= 20'd0;
      bit_cnt_r   <= 4'd0;
      score_bcd_r <= 12'd0;
      blood_q_r   <= 7'd100;
      flash_cnt_r <= 8'd0;
      is_hud_r    <= 1'b0;
      hud_index_r <= 5'd0;
      is_digit_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      score_bcd_r <= score_bcd_s;
      blood_q_r   <= blood_d_s;
      flash_cnt_r <= flash_d_s;
      is_hud_r    <= bar_any_s;
      hud_index_r <= hud_idx_s;
      is_digit_r  <= dig_reg_s && !bar_any_s;
    end
  end

  assign is_hud    = is_hud_r;
  assign hud_index = hud_index_r;
  assign is_digit  = is_digit_r;
  assign Score_BCD = score_bcd_r;
  assign Conv_Busy = (state_r != IDLE);
  assign Blood_Low = blood_low_s;

endmodule

// File: tb/tb_hud_overlay.sv
// Self-checking bench for hud_overlay: behavioural frame/pixel model plus directed literal checks.
module tb_hud_overlay;
  localparam int BX = 8, BY = 8, BH = 6, DX = 280, DY = 8, FL = 8, LOWT = 25;

  logic        Clk = 1'b0, Reset = 1'b1, game_frame_clk_rising_edge = 1'b0, Game_Over_On = 1'b0;
  logic [8:0]  PixelX = 9'd0, PixelY = 9'd0;
  logic [9:0]  Player_Blood = 10'd100;
  logic [7:0]  Total_Score = 8'd0;
  logic        is_hud, is_digit, Conv_Busy, Blood_Low;
  logic [4:0]  hud_index;
  logic [9:0]  digit_address;
  logic [11:0] Score_BCD;

  hud_overlay #(.BAR_X(BX), .BAR_Y(BY), .BAR_H(BH), .DIGIT_X(DX), .DIGIT_Y(DY),
                .FLASH_FRAMES(FL), .LOW_THRESHOLD(LOWT)) dut (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(game_frame_clk_rising_edge),
    .PixelX(PixelX), .PixelY(PixelY), .Player_Blood(Player_Blood), .Total_Score(Total_Score),
    .Game_Over_On(Game_Over_On), .is_hud(is_hud), .hud_index(hud_index), .is_digit(is_digit),
    .digit_address(digit_address), .Score_BCD(Score_BCD), .Conv_Busy(Conv_Busy), .Blood_Low(Blood_Low));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  // model state
  int m_blood = 100, m_flash = 0, m_bcd = 0, m_c = 0, m_pend = 0;
  int exp_hud = 0, exp_idx = 0, exp_dig = 0, cur_x = 0, cur_y = 0;
  bit chk_on = 1'b0;
  int b_in = 100, s_in = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int to_bcd(input int s);
    return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
  endfunction

  function automatic bit in_bar(input int x, input int y);
    return (x >= BX - 1) && (x <= BX + 100) && (y >= BY - 1) && (y <= BY + BH);
  endfunction

  function automatic bit in_digits(input int x, input int y);
    return (x >= DX) && (x <= DX + 23) && (y >= DY) && (y <= DY + 7);
  endfunction

  function automatic int bar_color(input int x, input int y);
    if (!((x >= BX) && (x <= BX + 99) && (y >= BY) && (y <= BY + BH - 1))) return 0;
    if (x - BX >= m_blood) return 5;
    if (m_flash != 0) return 4;
    if (m_blood < LOWT) return 3;
    return 2;
  endfunction

  function automatic int digit_addr(input int x, input int y);
    int d, v;
    if (!in_digits(x, y)) return 0;
    d = (x - DX) / 8;
    v = (d == 0) ? (m_bcd / 256) : (d == 1) ? ((m_bcd / 16) % 16) : (m_bcd % 16);
    return v * 64 + (y - DY) * 8 + ((x - DX) % 8);
  endfunction

  task automatic check_now();
    chk("is_hud", 32'(is_hud), 32'(exp_hud));
    chk("hud_index", 32'(hud_index), 32'(exp_idx));
    chk("is_digit", 32'(is_digit), 32'(exp_dig));
    chk("digit_address", 32'(digit_address), 32'(digit_addr(cur_x, cur_y)));
    chk("Score_BCD", 32'(Score_BCD), 32'(m_bcd));
    chk("Conv_Busy", 32'(Conv_Busy), 32'(m_c != 0));
    chk("Blood_Low", 32'(Blood_Low), 32'(m_blood < LOWT));
  endtask

  // One clock: check outputs, drive inputs, advance the model across the next rising edge.
  task automatic cycle(input bit rst, input bit fe, input int blood, input int score,
                       input bit go, input int x, input int y);
    int nb;
    if (chk_on) check_now();
    Reset = rst; game_frame_clk_rising_edge = fe; Player_Blood = 10'(blood);
    Total_Score = 8'(score); Game_Over_On = go; PixelX = 9'(x); PixelY = 9'(y);
    cur_x = x; cur_y = y; b_in = blood; s_in = score;
    if (rst) begin
      m_blood = 100; m_flash = 0; m_bcd = 0; m_c = 0;
      exp_hud = 0; exp_idx = 0; exp_dig = 0;
    end else begin
      exp_hud = in_bar(x, y);
      exp_idx = bar_color(x, y);
      exp_dig = in_digits(x, y) && !in_bar(x, y);
      if (fe) begin
        nb = (blood > 100) ? 100 : blood;
        if (nb < m_blood) m_flash = FL;
        else if (m_flash > 0) m_flash--;
        m_blood = nb;
      end
      if (go) m_flash = 0;
      if (fe) begin
        m_c = 1; m_pend = score;
      end else if (m_c > 0) begin
        m_c++;
        if (m_c == 10) begin m_bcd = to_bcd(m_pend); m_c = 0; end
      end
    end
    chk_on = 1'b1;
    @(negedge Clk);
  endtask

  task automatic idle(input int x, input int y);
    cycle(1'b0, 1'b0, b_in, s_in, 1'b0, x, y);
  endtask

  initial begin
    int n;
    bit saw099;
    cycle(1'b1, 1'b0, 100, 0, 1'b0, BX + 50, BY);
    cycle(1'b1, 1'b0, 100, 0, 1'b0, BX + 50, BY);
    idle(BX + 50, BY);
    chk("rst_is_hud", 32'(is_hud), 32'd1);
    chk("rst_index", 32'(hud_index), 32'd2);
    chk("rst_bcd", 32'(Score_BCD), 32'h000);

    // conversion of 255
    cycle(1'b0, 1'b1, 100, 255, 1'b0, BX + 50, BY);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Conv_Busy) break;
      n++;
      idle(0, 0);
    end
    chk("busy_len", 32'(n), 32'd9);
    chk("bcd_255", 32'(Score_BCD), 32'h255);

    // retrigger 99 then 7
    cycle(1'b0, 1'b1, 100, 99, 1'b0, 0, 0);
    repeat (3) idle(0, 0);
    cycle(1'b0, 1'b1, 100, 7, 1'b0, 0, 0);
    saw099 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (Score_BCD == 12'h099) saw099 = 1'b1;
      idle(0, 0);
    end
    chk("bcd_007", 32'(Score_BCD), 32'h007);
    chk("no_099", 32'(saw099), 32'd0);

    // damage flash
    cycle(1'b0, 1'b1, 90, 7, 1'b0, 0, 0);
    idle(BX + 10, BY);
    chk("flash_idx", 32'(hud_index), 32'd4);
    idle(BX + 95, BY + 1);
    chk("empty_idx", 32'(hud_index), 32'd5);
    repeat (8) begin cycle(1'b0, 1'b1, 90, 7, 1'b0, 0, 0); idle(0, 0); end
    idle(BX + 10, BY);
    chk("flash_done_idx", 32'(hud_index), 32'd2);

    // low blood, then clamp
    cycle(1'b0, 1'b1, 20, 7, 1'b0, 0, 0);
    idle(BX + 5, BY);
    chk("blood_low", 32'(Blood_Low), 32'd1);
    chk("low_flash_idx", 32'(hud_index), 32'd4);
    repeat (8) begin cycle(1'b0, 1'b1, 20, 7, 1'b0, 0, 0); idle(0, 0); end
    idle(BX + 5, BY + 2);
    chk("low_idx", 32'(hud_index), 32'd3);
    cycle(1'b0, 1'b1, 300, 7, 1'b0, 0, 0);
    idle(BX + 99, BY);
    chk("clamp_full_idx", 32'(hud_index), 32'd2);
    chk("clamp_not_low", 32'(Blood_Low), 32'd0);
    idle(BX + 100, BY);
    chk("border_hud", 32'(is_hud), 32'd1);
    chk("border_idx", 32'(hud_index), 32'd0);

    // digit address for 142
    cycle(1'b0, 1'b1, 100, 142, 1'b0, 0, 0);
    repeat (10) idle(0, 0);
    idle(DX + 13, DY + 2);
    chk("digit_addr_277", 32'(digit_address), 32'd277);
    chk("is_digit", 32'(is_digit), 32'd1);

    // reset during conversion
    cycle(1'b0, 1'b1, 100, 200, 1'b0, 0, 0);
    repeat (3) idle(0, 0);
    cycle(1'b1, 1'b0, 100, 200, 1'b0, 0, 0);
    chk("rst_mid_bcd", 32'(Score_BCD), 32'd0);
    chk("rst_mid_busy", 32'(Conv_Busy), 32'd0);
    idle(0, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int x, y, b, r;
      bit fe;
      r = int'($urandom_range(0, 2));
      if (r == 0) begin
        x = BX - 2 + int'($urandom_range(0, 104)); y = BY - 2 + int'($urandom_range(0, BH + 3));
      end else if (r == 1) begin
        x = DX - 2 + int'($urandom_range(0, 27)); y = DY - 2 + int'($urandom_range(0, 11));
      end else begin
        x = int'($urandom_range(0, 319)); y = int'($urandom_range(0, 239));
      end
      r = int'($urandom_range(0, 9));
      if (r < 4)      b = b_in;
      else if (r < 7) b = ((b_in > 100) ? 100 : b_in) - int'($urandom_range(1, 15));
      else if (r < 8) b = 300;
      else            b = int'($urandom_range(0, 127));
      if (b < 0) b = 0;
      fe = ($urandom_range(0, 11) == 0);
      cycle(1'b0, fe, b, int'($urandom_range(0, 255)), ($urandom_range(0, 99) == 0), x, y);
    end
    check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
